vga_hv_sync_gen: RTL and testbench

VGA_HV_SYNC_GEN -- requirements
Module: vga_hv_sync_gen

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/vga_hv_sync_gen_if.sv | 14 +
 rtl/vga_axis_timer.sv | 44 ++++
 rtl/vga_hv_sync_gen.sv | 74 +++++++
 tb/tb_vga_hv_sync_gen.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Timing constants and counter type shared by the VGA sync generator.
// Defaults describe standard 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  // Horizontal defaults, in pixel clocks
  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;

  // Vertical defaults, in lines
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  // Derived totals and sync windows (start inclusive, end exclusive)
  localparam int unsigned H_TOTAL_DEF      = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int unsigned H_SYNC_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int unsigned H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int unsigned V_TOTAL_DEF      = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
  localparam int unsigned V_SYNC_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int unsigned V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

endpackage

// File: rtl/vga_hv_sync_gen_if.sv
// Video timing bundle: sync strobes, raster position and visible flag.
interface vga_hv_sync_gen_if;
  import vga_timing_pkg::*;

  logic hsync;
  logic vsync;
  cnt_t countH;
  cnt_t countV;
  logic inDisplay;

  modport master (output hsync, vsync, countH, countV, inDisplay);
  modport slave  (input  hsync, vsync, countH, countV, inDisplay);

endinterface

// File: rtl/vga_axis_timer.sv
// One raster axis: wrapping position counter with sync-window and visible decodes.
// Decodes are combinational from the count register, so they line up with it.
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int unsigned VISIBLE = 640,
  parameter int unsigned FRONT   = 16,
  parameter int unsigned SYNC    = 96,
  parameter int unsigned BACK    = 48
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output cnt_t count,
  output logic wrap_c,
  output logic sync_c,
  output logic visible_c
);

  localparam int unsigned TOTAL      = VISIBLE + FRONT + SYNC + BACK;
  localparam int unsigned SYNC_START = VISIBLE + FRONT;
  localparam int unsigned SYNC_END   = SYNC_START + SYNC;

  // Last position of the axis reached while advancing
  assign wrap_c = en && (count == CNT_W'(TOTAL - 1));

  // Position counter: advance when enabled, return to zero after the last position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      if (wrap_c) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // Window decodes against the registered position
  assign sync_c    = (count >= CNT_W'(SYNC_START)) && (count < CNT_W'(SYNC_END));
  assign visible_c = (count < CNT_W'(VISIBLE));

endmodule

// File: rtl/vga_hv_sync_gen.sv
// VGA horizontal/vertical sync generator.
// Sync polarity: active-low by default; define VGA_SYNC_ACTIVE_HIGH_EN for active-high.
// Total line and frame counts must stay below 1024.
module vga_hv_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF
) (
  input logic               clk,
  input logic               reset,
  vga_hv_sync_gen_if.master vga
);

  cnt_t h_count;
  cnt_t v_count;
  logic h_wrap;
  logic h_sync_win;
  logic h_visible;
  logic v_wrap_unused;
  logic v_sync_win;
  logic v_visible;

  // Column counter, advances every pixel clock
  vga_axis_timer #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_timer (
    .clk       (clk),
    .rst_n     (reset),
    .en        (1'b1),
    .count     (h_count),
    .wrap_c    (h_wrap),
    .sync_c    (h_sync_win),
    .visible_c (h_visible)
  );

  // Line counter, advances on the column wrap so both wrap together at frame end
  vga_axis_timer #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_timer (
    .clk       (clk),
    .rst_n     (reset),
    .en        (h_wrap),
    .count     (v_count),
    .wrap_c    (v_wrap_unused),
    .sync_c    (v_sync_win),
    .visible_c (v_visible)
  );

  assign vga.countH    = h_count;
  assign vga.countV    = v_count;
  assign vga.inDisplay = h_visible && v_visible;

`ifdef VGA_SYNC_ACTIVE_HIGH_EN
  assign vga.hsync = h_sync_win;
  assign vga.vsync = v_sync_win;
`else
  assign vga.hsync = ~h_sync_win;
  assign vga.vsync = ~v_sync_win;
`endif

endmodule

// File: tb/tb_vga_hv_sync_gen.sv
// Directed bench for vga_hv_sync_gen: a default-timing instance for line
// behaviour and a reduced-timing instance (32x19) for frame-level behaviour.
module tb_vga_hv_sync_gen;
  import vga_timing_pkg::*;

`ifdef VGA_SYNC_ACTIVE_HIGH_EN
  localparam logic ACT = 1'b1;
`else
  localparam logic ACT = 1'b0;
`endif
  localparam logic IDLE = ACT ^ 1'b1;

  // Reduced timing: line 20+3+5+4=32, frame 10+2+3+4=19 lines, 608 clocks
  localparam int SH_TOT = 32;
  localparam int SV_TOT = 19;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   passed = 0;
  int   dh = 0, dv = 0, sh = 0, sv = 0;

  vga_hv_sync_gen_if dif ();
  vga_hv_sync_gen_if sif ();

  vga_hv_sync_gen dut_def (
    .clk   (clk),
    .reset (reset),
    .vga   (dif)
  );

  vga_hv_sync_gen #(
    .H_VISIBLE (20), .H_FRONT (3), .H_SYNC (5), .H_BACK (4),
    .V_VISIBLE (10), .V_FRONT (2), .V_SYNC (3), .V_BACK (4)
  ) dut_small (
    .clk   (clk),
    .reset (reset),
    .vga   (sif)
  );

  always #5 clk = ~clk;

  // Advance one clock, update the position models, sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      if (dh == 799) begin
        dh = 0;
        dv = (dv == 524) ? 0 : dv + 1;
      end else dh++;
      if (sh == SH_TOT - 1) begin
        sh = 0;
        sv = (sv == SV_TOT - 1) ? 0 : sv + 1;
      end else sh++;
    end
    #1;
  endtask

  // Run the small instance's model to a position (bounded)
  task automatic goto_small(input int h, input int v);
    for (int i = 0; i < 1300; i++) begin
      if (sh == h && sv == v) break;
      tick();
    end
    if (!(sh == h && sv == v)) begin
      checks++;
      $display("FAIL goto_small: position (%0d,%0d) not reached, at (%0d,%0d)", h, v, sh, sv);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    checks += 6;
    if (dif.countH !== 10'd0) $display("FAIL rst_countH: got %0d expected 0", dif.countH); else passed++;
    if (dif.countV !== 10'd0) $display("FAIL rst_countV: got %0d expected 0", dif.countV); else passed++;
    if (dif.hsync !== IDLE) $display("FAIL rst_hsync: got %b expected %b", dif.hsync, IDLE); else passed++;
    if (dif.vsync !== IDLE) $display("FAIL rst_vsync: got %b expected %b", dif.vsync, IDLE); else passed++;
    if (dif.inDisplay !== 1'b1) $display("FAIL rst_inDisplay: got %b expected 1", dif.inDisplay); else passed++;
    if (sif.countH !== 10'd0) $display("FAIL rst_small_countH: got %0d expected 0", sif.countH); else passed++;
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks += 2;
    if (dif.countH !== 10'd1) $display("FAIL release_countH: got %0d expected 1", dif.countH); else passed++;
    if (dif.countV !== 10'd0) $display("FAIL release_countV: got %0d expected 0", dif.countV); else passed++;
  endtask

  task automatic test_hsweep();
    int low_cnt = 0;
    logic exp_hs;
    for (int i = 0; i < 800; i++) begin
      if (dh == 799) break;
      exp_hs = (dh >= 656 && dh < 752) ? ACT : IDLE;
      if (dif.hsync === ACT) low_cnt++;
      checks += 2;
      if (dif.countH !== 10'(dh)) $display("FAIL hsweep_countH: got %0d expected %0d", dif.countH, dh); else passed++;
      if (dif.hsync !== exp_hs) $display("FAIL hsweep_hsync at %0d: got %b expected %b", dh, dif.hsync, exp_hs); else passed++;
      if (dh == 639 || dh == 640) begin
        checks++;
        if (dif.inDisplay !== (dh == 639)) $display("FAIL inDisplay_(%0d,0): got %b expected %b", dh, dif.inDisplay, dh == 639);
        else passed++;
      end
      tick();
    end
    checks += 4;
    if (dif.countH !== 10'd799) $display("FAIL hsweep_last: got %0d expected 799", dif.countH); else passed++;
    if (dif.countV !== 10'd0) $display("FAIL hsweep_lastV: got %0d expected 0", dif.countV); else passed++;
    tick();
    if (dif.countH !== 10'd0 || dif.countV !== 10'd1)
      $display("FAIL hwrap: got (%0d,%0d) expected (0,1)", dif.countH, dif.countV);
    else passed++;
    if (low_cnt != 96) $display("FAIL hsync_width: got %0d expected 96", low_cnt); else passed++;
  endtask

  task automatic test_frame();
    int n = 0;
    int vact = 0;
    logic exp_vs;
    goto_small(0, 0);
    checks++;
    if (sif.countH !== 10'd0 || sif.countV !== 10'd0)
      $display("FAIL frame_start: got (%0d,%0d) expected (0,0)", sif.countH, sif.countV);
    else passed++;
    for (int i = 0; i < 700; i++) begin
      exp_vs = (sv >= 12 && sv < 15) ? ACT : IDLE;
      if (sif.vsync === ACT) vact++;
      checks += 3;
      if (sif.countH !== 10'(sh) || sif.countV !== 10'(sv))
        $display("FAIL frame_pos: got (%0d,%0d) expected (%0d,%0d)", sif.countH, sif.countV, sh, sv);
      else passed++;
      if (sif.vsync !== exp_vs) $display("FAIL frame_vsync line %0d: got %b expected %b", sv, sif.vsync, exp_vs); else passed++;
      if (sif.hsync !== ((sh >= 23 && sh < 28) ? ACT : IDLE))
        $display("FAIL frame_hsync col %0d: got %b", sh, sif.hsync);
      else passed++;
      tick();
      n++;
      if (sif.countH === 10'd0 && sif.countV === 10'd0) break;
    end
    checks += 2;
    if (n != 608) $display("FAIL frame_period: got %0d expected 608", n); else passed++;
    if (vact != 96) $display("FAIL vsync_width: got %0d expected 96", vact); else passed++;
  endtask

  task automatic test_in_display();
    int pts_h [5] = '{19, 20, 0, 0, 31};
    int pts_v [5] = '{0, 0, 9, 10, 18};
    logic pts_e [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      goto_small(pts_h[k], pts_v[k]);
      checks += 2;
      if (sif.countH !== 10'(pts_h[k]) || sif.countV !== 10'(pts_v[k]))
        $display("FAIL point_pos: got (%0d,%0d) expected (%0d,%0d)", sif.countH, sif.countV, pts_h[k], pts_v[k]);
      else passed++;
      if (sif.inDisplay !== pts_e[k])
        $display("FAIL inDisplay_(%0d,%0d): got %b expected %b", pts_h[k], pts_v[k], sif.inDisplay, pts_e[k]);
      else passed++;
    end
    tick();
    checks++;
    if (sif.countH !== 10'd0 || sif.countV !== 10'd0)
      $display("FAIL frame_wrap: got (%0d,%0d) expected (0,0)", sif.countH, sif.countV);
    else passed++;
  endtask

  task automatic test_mid_reset();
    goto_small(25, 12);
    checks += 2;
    if (sif.hsync !== ACT || sif.vsync !== ACT)
      $display("FAIL pre_reset_sync: got h=%b v=%b expected %b", sif.hsync, sif.vsync, ACT);
    else passed++;
    if (sif.inDisplay !== 1'b0) $display("FAIL pre_reset_inDisplay: got %b expected 0", sif.inDisplay); else passed++;
    #2;
    reset = 1'b0;
    #1;
    dh = 0; dv = 0; sh = 0; sv = 0;
    checks += 3;
    if (sif.countH !== 10'd0 || sif.countV !== 10'd0)
      $display("FAIL async_reset_pos: got (%0d,%0d) expected (0,0)", sif.countH, sif.countV);
    else passed++;
    if (sif.hsync !== IDLE || sif.vsync !== IDLE)
      $display("FAIL async_reset_sync: got h=%b v=%b expected %b", sif.hsync, sif.vsync, IDLE);
    else passed++;
    if (sif.inDisplay !== 1'b1 || dif.countH !== 10'd0)
      $display("FAIL async_reset_misc: got inDisplay=%b def_countH=%0d expected 1,0", sif.inDisplay, dif.countH);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks += 2;
    if (sif.countH !== 10'd1 || sif.countV !== 10'd0)
      $display("FAIL rerelease_small: got (%0d,%0d) expected (1,0)", sif.countH, sif.countV);
    else passed++;
    if (dif.countH !== 10'd1 || dif.countV !== 10'd0)
      $display("FAIL rerelease_def: got (%0d,%0d) expected (1,0)", dif.countH, dif.countV);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_hsweep();
    test_frame();
    test_in_display();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
